cpu_phase_sequencer: RTL and testbench
======================================

Name: cpu_phase_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit accumulator CPU. It steps every instruction through fetch, decode, execute, memory and writeback phases.
- It drives the strobes for the instruction register, program counter, data memory, accumulator and ALU.
- It also runs program-load mode, in which external bytes are written into instruction memory.
- It sits between the instruction-memory/IR opcode field and the PC, data-memory and accumulator enables, and replaces the single-cycle enable decoding.

Parameters:
- COUNT_W, 8, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  program-load request; highest priority.
- data_valid  in  1  a program byte is present on the external data_in bus (used in LOAD only).
- start  in  1  begin or resume execution from IDLE or HALT.
- opcode  in  3  opcode field of the instruction register.
- acc_zero  in  1  accumulator equals 0.
- ir_load  out  1  latch instruction register.
- pc_inc  out  1  PC <= PC+1 (5-bit, wraps 31->0).
- pc_load  out  1  PC <= IR address field.
- pc_clr  out  1  PC <= 0.
- im_wr  out  1  write data_in to instruction memory at PC.
- mem_rd  out  1  data-memory read enable.
- mem_wr  out  1  data-memory write enable.
- acc_load  out  1  accumulator <= ALU result.
- alu_op  out  3  ALU operation. Equals opcode in MEM and WB, otherwise 000.
- phase  out  3  current state encoding.
- busy  out  1  high in FETCH..WB.
- halted  out  1  high in HALT.
- instr_count  out  COUNT_W  retired instruction count; wraps.

Behaviour:
- Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- State encodings: IDLE=0, LOAD=1, FETCH=2, DECODE=3, EXEC=4, MEM=5, WB=6, HALT=7.
- Reset (reset=0, asynchronous): state=IDLE, instr_count=0, all strobes 0, alu_op=000, busy=0, halted=0.
- Outputs are combinational from state (and opcode/acc_zero where noted).
- Only one of pc_inc / pc_load / pc_clr may be high in any cycle.
- IDLE:
  - load=1 -> LOAD.
  - else start=1 -> FETCH.
  - else stay.
- LOAD:
  - im_wr = pc_inc = data_valid & load.
  - Entry from any state clears instr_count on the entry edge.
  - load=0 -> pc_clr=1 for that cycle, no write, -> IDLE.
- FETCH: ir_load=1 -> DECODE.
- DECODE:
  - pc_inc=1.
  - opcode=HLT -> HALT, retire; otherwise -> EXEC.
- EXEC:
  - SKZ: pc_inc=acc_zero, -> FETCH, retire.
  - JMP: pc_load=1, -> FETCH, retire.
  - STO: mem_wr=1, -> FETCH, retire.
  - ADD/AND/XOR/LDA: mem_rd=1 -> MEM.
- MEM: mem_rd=1, alu_op=opcode -> WB.
- WB: acc_load=1, alu_op=opcode -> FETCH, retire.
- HALT:
  - halted=1, strobes 0.
  - load=1 -> LOAD.
  - else start=1 -> FETCH; PC is not cleared, so execution resumes at the instruction after HLT.
- Retire: instr_count += 1 on the edge leaving the final state of an instruction.
- Cycles per instruction from FETCH: HLT 2, SKZ/JMP/STO 3, ADD/AND/XOR/LDA 5.
- Load priority: load=1 while in FETCH..WB or HALT aborts execution.
  - In that cycle all strobes are forced to 0, no retire, next state LOAD.
  - load and start together always select load.
- start is ignored in FETCH..WB and in LOAD.
- opcode is sampled only in DECODE..WB; it must be stable after ir_load.
- Reset asserted mid-instruction returns to IDLE immediately, with no partial strobes after assertion.
- After reset release, the first edge evaluates IDLE transitions.

Test Plan:
- Reset, then load=1 with 4 cycles data_valid=1, then load=0 -> exactly 4 im_wr/pc_inc pulses, one pc_clr pulse, phase=0, instr_count=0.
- Program LDA,ADD,STO,HLT, start pulse -> phase sequence 2,3,4,5,6 | 2,3,4,5,6 | 2,3,4 | 2,3,7; halted=1; instr_count=4; alu_op=101 then 010 during MEM/WB; one mem_wr pulse.
- SKZ with acc_zero=1 -> EXEC pc_inc=1 (2 PC increments total); with acc_zero=0 -> 1 increment; both take 3 cycles.
- JMP -> pc_load=1 only in EXEC, pc_inc only in DECODE; next phase=2.
- load=1 asserted while in MEM of ADD -> that cycle has mem_rd=0, acc_load is never issued, next phase=1, instr_count=0.
- Reset asserted mid-WB (between edges) -> acc_load drops immediately, phase=0; with start=1 held, FETCH follows one edge after release.
- start and load both high in HALT -> LOAD entered; 256 retired instructions -> instr_count wraps to 0.

Source files
------------

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: multi-cycle fetch/decode/execute/memory/writeback control FSM with program-load mode
module cpu_phase_sequencer #(
  parameter int COUNT_W = 8
) (
  input  logic               clock_i,
  input  logic               reset_ni,
  input  logic               load_i,
  input  logic               data_valid_i,
  input  logic               start_i,
  input  logic [2:0]         opcode_i,
  input  logic               acc_zero_i,
  output logic               ir_load_o,
  output logic               pc_inc_o,
  output logic               pc_load_o,
  output logic               pc_clr_o,
  output logic               im_wr_o,
  output logic               mem_rd_o,
  output logic               mem_wr_o,
  output logic               acc_load_o,
  output logic [2:0]         alu_op_o,
  output logic [2:0]         phase_o,
  output logic               busy_o,
  output logic               halted_o,
  output logic [COUNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 running, abort, short_op, retire;

  assign running  = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
                    (state_q == S_MEM) || (state_q == S_WB);
  // A load request while executing or halted kills the current instruction outright.
  assign abort    = load_i && (running || state_q == S_HALT);
  // SKZ, JMP and STO finish in EXEC; the memory-operand instructions continue through MEM/WB.
  assign short_op = (opcode_i == OP_SKZ) || (opcode_i == OP_JMP) || (opcode_i == OP_STO);
  assign retire   = !load_i && (((state_q == S_DECODE) && (opcode_i == OP_HLT)) ||
                                ((state_q == S_EXEC) && short_op) || (state_q == S_WB));

  // State and retired-instruction counter registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and counter update; load overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = load_i ? S_LOAD : (start_i ? S_FETCH : S_IDLE);
      S_LOAD:   state_d = load_i ? S_LOAD : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (opcode_i == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC:   state_d = short_op ? S_FETCH : S_MEM;
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = load_i ? S_LOAD : (start_i ? S_FETCH : S_HALT);
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_LOAD;
    count_d = (state_d == S_LOAD) ? '0 : count_q + COUNT_W'(retire);
  end

  // Strobe decode from the current phase; an aborting cycle issues nothing.
  always_comb begin
    ir_load_o  = 1'b0;
    pc_inc_o   = 1'b0;
    pc_load_o  = 1'b0;
    pc_clr_o   = 1'b0;
    im_wr_o    = 1'b0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    acc_load_o = 1'b0;
    if (!abort) begin
      case (state_q)
        S_LOAD: begin
          im_wr_o  = load_i && data_valid_i;
          pc_inc_o = load_i && data_valid_i;
          pc_clr_o = !load_i;
        end
        S_FETCH:  ir_load_o = 1'b1;
        S_DECODE: pc_inc_o  = 1'b1;
        S_EXEC: begin
          pc_inc_o  = (opcode_i == OP_SKZ) && acc_zero_i;
          pc_load_o = (opcode_i == OP_JMP);
          mem_wr_o  = (opcode_i == OP_STO);
          mem_rd_o  = !short_op;
        end
        S_MEM:    mem_rd_o   = 1'b1;
        S_WB:     acc_load_o = 1'b1;
        default:  ir_load_o  = 1'b0;
      endcase
    end
  end

  assign alu_op_o      = ((state_q == S_MEM) || (state_q == S_WB)) ? opcode_i : 3'b000;
  assign phase_o       = state_q;
  assign busy_o        = running;
  assign halted_o      = (state_q == S_HALT);
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: randomized check of the phase sequencer against an instruction-level model
module tb_cpu_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0, data_valid = 1'b0, start = 1'b0, acc_zero = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       ir_load, pc_inc, pc_load, pc_clr, im_wr, mem_rd, mem_wr, acc_load;
  logic [2:0] alu_op, phase;
  logic       busy, halted;
  logic [7:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 loading, 2 running (k = cycle index within instruction), 3 halted.
  int mode = 0;
  int k    = 0;
  int cnt  = 0;

  cpu_phase_sequencer #(.COUNT_W(8)) dut (
    .clock_i(clk), .reset_ni(rst_n), .load_i(load), .data_valid_i(data_valid),
    .start_i(start), .opcode_i(opcode), .acc_zero_i(acc_zero),
    .ir_load_o(ir_load), .pc_inc_o(pc_inc), .pc_load_o(pc_load), .pc_clr_o(pc_clr),
    .im_wr_o(im_wr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .acc_load_o(acc_load),
    .alu_op_o(alu_op), .phase_o(phase), .busy_o(busy), .halted_o(halted),
    .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Cycles an instruction occupies starting from FETCH.
  function automatic int ilen(input logic [2:0] o);
    if (o == 3'd0) return 2;
    if (o == 3'd1 || o == 3'd6 || o == 3'd7) return 3;
    return 5;
  endfunction

  task automatic compare();
    logic [7:0] e_str;
    logic [2:0] e_ph, e_alu;
    logic [1:0] e_flg;
    e_str = '0; e_alu = '0; e_flg = '0; e_ph = 3'd0;
    case (mode)
      1: begin
        e_ph = 3'd1;
        if (load) e_str = {1'b0, data_valid, 2'b00, data_valid, 3'b000};
        else      e_str = 8'b0001_0000;
      end
      2: begin
        e_ph  = 3'(2 + k);
        e_flg = 2'b10;
        if (k >= 3) e_alu = opcode;
        if (!load) begin
          case (k)
            0: e_str = 8'b1000_0000;
            1: e_str = 8'b0100_0000;
            2: begin
              if (opcode == 3'd1)      e_str = {1'b0, acc_zero, 6'b0};
              else if (opcode == 3'd7) e_str = 8'b0010_0000;
              else if (opcode == 3'd6) e_str = 8'b0000_0010;
              else                     e_str = 8'b0000_0100;
            end
            3: e_str = 8'b0000_0100;
            default: e_str = 8'b0000_0001;
          endcase
        end
      end
      3: begin
        e_ph  = 3'd7;
        e_flg = 2'b01;
      end
      default: e_ph = 3'd0;
    endcase
    check("strobes", {ir_load, pc_inc, pc_load, pc_clr, im_wr, mem_rd, mem_wr, acc_load}, e_str);
    check("phase", phase, e_ph);
    check("alu_op", alu_op, e_alu);
    check("busy_halted", {busy, halted}, e_flg);
    check("instr_count", instr_count, cnt[7:0]);
  endtask

  task automatic advance();
    case (mode)
      0: begin
        if (load) begin mode = 1; cnt = 0; end
        else if (start) begin mode = 2; k = 0; end
      end
      1: if (!load) mode = 0;
      3: begin
        if (load) begin mode = 1; cnt = 0; end
        else if (start) begin mode = 2; k = 0; end
      end
      default: begin
        if (load) begin mode = 1; cnt = 0; end
        else if (k == ilen(opcode) - 1) begin
          cnt = (cnt + 1) % 256;
          if (opcode == 3'd0) mode = 3;
          else k = 0;
        end else k++;
      end
    endcase
  endtask

  // One clock: drive inputs, optionally pulse reset, compare, then step the model.
  task automatic cycle(input int load_pct, input int start_pct, input int rst_pct);
    @(negedge clk);
    rst_n      = 1'b1;
    load       = ($urandom_range(99) < load_pct);
    start      = ($urandom_range(99) < start_pct);
    data_valid = $urandom_range(1);
    acc_zero   = $urandom_range(1);
    if (mode != 2 || k == 0) opcode = 3'($urandom_range(7));
    if ($urandom_range(999) < rst_pct) begin
      #2;
      rst_n = 1'b0;
      mode = 0; k = 0; cnt = 0;
    end
    #1;
    compare();
    @(posedge clk);
    if (rst_n) advance();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    compare();
    for (int i = 0; i < 4000; i++) cycle(8, 40, 6);
    for (int i = 0; i < 3000; i++) cycle(0, 50, 0);
    for (int i = 0; i < 1500; i++) cycle(15, 60, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
